// File: rtl/rvne_pipe_pkg.sv
// Shared pipeline definitions: default widths, skid-stage state encodings
// and the bit offsets used to pack a MEM/WB payload into a flat vector.
package rvne_pipe_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_VLEN    = 512;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_VL_W    = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } memwb_state_e;

  // Control bits sit at the bottom of the packed payload, followed by VL,
  // rd, alu result, scalar load data and finally the optional vector data.
  localparam int OFF_MEMTOREG = 0;
  localparam int OFF_REGWRITE = 1;
  localparam int OFF_WVRWRITE = 2;
  localparam int OFF_SVRWRITE = 3;
  localparam int OFF_VL       = 4;

  function automatic int memwb_scalar_width(int xlen, int raddr_w, int vl_w);
    return OFF_VL + vl_w + raddr_w + 2 * xlen;
  endfunction

endpackage

// File: rtl/memwb_skid_stage_if.sv
// MEM/WB handshake bundle: the MEM-side payload with valid/ready going in,
// and the WB-side payload with valid/ready coming out of the stage.
interface memwb_skid_stage_if
  import rvne_pipe_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int VLEN    = DEF_VLEN,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int VL_W    = DEF_VL_W
);

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    readdata_in;
  logic [VLEN-1:0]    readdata512_in;
  logic [XLEN-1:0]    alu_result_in;
  logic [RADDR_W-1:0] rd_in;
  logic               memtoreg_in;
  logic               regwrite_in;
  logic               WVRwrite_in;
  logic               SVRwrite_in;
  logic [VL_W-1:0]    VL_in;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    readdata_out;
  logic [VLEN-1:0]    readdata512_out;
  logic [XLEN-1:0]    alu_result_out;
  logic [RADDR_W-1:0] rd_out;
  logic               memtoreg_out;
  logic               regwrite_out;
  logic               WVRwrite_out;
  logic               SVRwrite_out;
  logic [VL_W-1:0]    VL_out;

  // Surrounding pipeline: drives the MEM payload and the WB ready.
  modport master (
    output in_valid, readdata_in, readdata512_in, alu_result_in, rd_in,
           memtoreg_in, regwrite_in, WVRwrite_in, SVRwrite_in, VL_in,
           out_ready,
    input  in_ready, out_valid, readdata_out, readdata512_out,
           alu_result_out, rd_out, memtoreg_out, regwrite_out,
           WVRwrite_out, SVRwrite_out, VL_out
  );

  // The skid stage itself.
  modport slave (
    input  in_valid, readdata_in, readdata512_in, alu_result_in, rd_in,
           memtoreg_in, regwrite_in, WVRwrite_in, SVRwrite_in, VL_in,
           out_ready,
    output in_ready, out_valid, readdata_out, readdata512_out,
           alu_result_out, rd_out, memtoreg_out, regwrite_out,
           WVRwrite_out, SVRwrite_out, VL_out
  );

endinterface

// File: rtl/memwb_skid_stage_pipe_slot.sv
// One payload slot of the skid buffer: a flat register with a load enable
// that clears to zero on reset.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture the offered payload only when the control logic asks for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a two-entry skid buffer. MAIN always drives the
// WB outputs; SKID absorbs the one extra payload that can arrive while WB is
// stalled, so in_ready only ever depends on registered state.
module memwb_skid_stage
  import rvne_pipe_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int VLEN    = DEF_VLEN,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int VL_W    = DEF_VL_W,
  parameter bit VEC_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  memwb_skid_stage_if.slave   bus,
  output logic [1:0]          occupancy
);

  localparam int OFF_RD    = OFF_VL + VL_W;
  localparam int OFF_ALU   = OFF_RD + RADDR_W;
  localparam int OFF_RDATA = OFF_ALU + XLEN;
  localparam int OFF_VDATA = OFF_RDATA + XLEN;
  localparam int SW        = memwb_scalar_width(XLEN, RADDR_W, VL_W);
  localparam int PW        = SW + (VEC_EN ? VLEN : 0);

  memwb_state_e state_q, state_d;
  logic [1:0]   occ_q, occ_d;
  logic         push, pop;
  logic         main_load, skid_load, main_from_skid;
  logic [SW-1:0] in_scalar;
  logic [PW-1:0] in_pkt, main_d, main_q, skid_q;

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign in_scalar = {bus.readdata_in, bus.alu_result_in, bus.rd_in, bus.VL_in,
                      bus.SVRwrite_in, bus.WVRwrite_in, bus.regwrite_in,
                      bus.memtoreg_in};

  // The vector field only exists in the slots when the vector path is built.
  generate
    if (VEC_EN) begin : g_vec
      assign in_pkt = {bus.readdata512_in, in_scalar};
      assign bus.readdata512_out = main_q[OFF_VDATA +: VLEN];
    end else begin : g_novec
      assign in_pkt = in_scalar;
      assign bus.readdata512_out = '0;
    end
  endgenerate

  assign main_d = main_from_skid ? skid_q : in_pkt;

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_pkt),
    .q     (skid_q)
  );

  assign bus.readdata_out   = main_q[OFF_RDATA +: XLEN];
  assign bus.alu_result_out = main_q[OFF_ALU +: XLEN];
  assign bus.rd_out         = main_q[OFF_RD +: RADDR_W];
  assign bus.VL_out         = main_q[OFF_VL +: VL_W];
  assign bus.memtoreg_out   = main_q[OFF_MEMTOREG] & bus.out_valid;
  assign bus.regwrite_out   = main_q[OFF_REGWRITE] & bus.out_valid;
  assign bus.WVRwrite_out   = main_q[OFF_WVRWRITE] & bus.out_valid;
  assign bus.SVRwrite_out   = main_q[OFF_SVRWRITE] & bus.out_valid;
  assign occupancy          = occ_q;

  // State and occupancy registers; reset drops everything held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

  // Next state and slot loads; flush wins over any push in the same cycle.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy tracks the net effect of push and pop each cycle.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage: a vector-enabled instance and a
// VEC_EN=0 instance receive identical stimulus and are checked against
// hand-computed values.
module tb_memwb_skid_stage;
  import rvne_pipe_pkg::*;

  logic clk;
  logic reset;
  logic flush;
  logic [1:0] occupancy;
  logic [1:0] occupancy0;
  int total;
  int bad;

  memwb_skid_stage_if #(.XLEN(32), .VLEN(512), .RADDR_W(5), .VL_W(2)) bus ();
  memwb_skid_stage_if #(.XLEN(32), .VLEN(512), .RADDR_W(5), .VL_W(2)) bus0 ();

  memwb_skid_stage #(.XLEN(32), .VLEN(512), .RADDR_W(5), .VL_W(2), .VEC_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave),
    .occupancy (occupancy)
  );

  memwb_skid_stage #(.XLEN(32), .VLEN(512), .RADDR_W(5), .VL_W(2), .VEC_EN(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus0.slave),
    .occupancy (occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [511:0] vdata,
                               input logic [3:0] ctrl, input logic [1:0] vl);
    bus.in_valid       = v;
    bus.rd_in          = rd;
    bus.alu_result_in  = alu;
    bus.readdata_in    = rdata;
    bus.readdata512_in = vdata;
    bus.memtoreg_in    = ctrl[0];
    bus.regwrite_in    = ctrl[1];
    bus.WVRwrite_in    = ctrl[2];
    bus.SVRwrite_in    = ctrl[3];
    bus.VL_in          = vl;
    bus0.in_valid       = v;
    bus0.rd_in          = rd;
    bus0.alu_result_in  = alu;
    bus0.readdata_in    = rdata;
    bus0.readdata512_in = vdata;
    bus0.memtoreg_in    = ctrl[0];
    bus0.regwrite_in    = ctrl[1];
    bus0.WVRwrite_in    = ctrl[2];
    bus0.SVRwrite_in    = ctrl[3];
    bus0.VL_in          = vl;
  endtask

  task automatic setReady(input logic r);
    bus.out_ready  = r;
    bus0.out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    setReady(1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, '0, 4'b0000, 2'd0);
    #3;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_occ", occupancy, 2'd0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    reset = 1'b0;

    // pass-through with vector data and the VEC_EN=0 instance alongside
    setReady(1'b1);
    applyStimulus(1'b1, 5'd5, 32'h1234, 32'hDEADBEEF, '1, 4'b1110, 2'd3);
    tick();
    checkOutput("pt_out_valid", bus.out_valid, 1'b1);
    checkOutput("pt_rd", bus.rd_out, 5'd5);
    checkOutput("pt_alu", bus.alu_result_out, 32'h1234);
    checkOutput("pt_regwrite", bus.regwrite_out, 1'b1);
    checkOutput("pt_memtoreg", bus.memtoreg_out, 1'b0);
    checkOutput("pt_occ", occupancy, 2'd1);
    checkOutput("pt_vdata", bus.readdata512_out, {512{1'b1}});
    checkOutput("nv_vdata", bus0.readdata512_out, 512'd0);
    checkOutput("nv_rdata", bus0.readdata_out, 32'hDEADBEEF);
    checkOutput("nv_rd", bus0.rd_out, 5'd5);
    checkOutput("nv_vl", bus0.VL_out, 2'd3);
    checkOutput("nv_svr", bus0.SVRwrite_out, 1'b1);
    checkOutput("nv_wvr", bus0.WVRwrite_out, 1'b1);

    applyStimulus(1'b1, 5'd6, 32'h2222, 32'h0, '0, 4'b0010, 2'd0);
    tick();
    checkOutput("b2b_occ", occupancy, 2'd1);
    checkOutput("b2b_rd", bus.rd_out, 5'd6);
    checkOutput("b2b_alu", bus.alu_result_out, 32'h2222);
    checkOutput("b2b_wvr", bus.WVRwrite_out, 1'b0);

    // bubble: pop without a new push
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, '0, 4'b0000, 2'd0);
    tick();
    checkOutput("bub_out_valid", bus.out_valid, 1'b0);
    checkOutput("bub_regwrite", bus.regwrite_out, 1'b0);
    checkOutput("bub_alu_hold", bus.alu_result_out, 32'h2222);
    checkOutput("bub_occ", occupancy, 2'd0);

    // back-pressure: A and B held, C waits at the input
    setReady(1'b0);
    applyStimulus(1'b1, 5'd1, 32'hA1, 32'h0, '0, 4'b0011, 2'd1);
    tick();
    checkOutput("bp_a_occ", occupancy, 2'd1);
    applyStimulus(1'b1, 5'd2, 32'hB2, 32'h0, '0, 4'b0010, 2'd2);
    tick();
    checkOutput("bp_full_occ", occupancy, 2'd2);
    checkOutput("bp_full_ready", bus.in_ready, 1'b0);
    checkOutput("bp_full_rd", bus.rd_out, 5'd1);
    checkOutput("bp_full_alu", bus.alu_result_out, 32'hA1);
    checkOutput("bp_full_m2r", bus.memtoreg_out, 1'b1);
    checkOutput("bp_full_vl", bus.VL_out, 2'd1);
    applyStimulus(1'b1, 5'd3, 32'hC3, 32'h0, '0, 4'b0010, 2'd3);
    tick();
    checkOutput("bp_hold_occ", occupancy, 2'd2);
    checkOutput("bp_hold_rd", bus.rd_out, 5'd1);
    setReady(1'b1);
    tick();
    checkOutput("bp_b_rd", bus.rd_out, 5'd2);
    checkOutput("bp_b_alu", bus.alu_result_out, 32'hB2);
    checkOutput("bp_b_m2r", bus.memtoreg_out, 1'b0);
    checkOutput("bp_b_occ", occupancy, 2'd1);
    checkOutput("bp_b_ready", bus.in_ready, 1'b1);
    tick();
    checkOutput("bp_c_rd", bus.rd_out, 5'd3);
    checkOutput("bp_c_alu", bus.alu_result_out, 32'hC3);
    checkOutput("bp_c_occ", occupancy, 2'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, '0, 4'b0000, 2'd0);
    tick();
    checkOutput("bp_drain_valid", bus.out_valid, 1'b0);
    checkOutput("bp_drain_occ", occupancy, 2'd0);

    // flush while full with in_valid high
    setReady(1'b0);
    applyStimulus(1'b1, 5'd7, 32'hD7, 32'h0, '0, 4'b0010, 2'd0);
    tick();
    applyStimulus(1'b1, 5'd8, 32'hE8, 32'h0, '0, 4'b0010, 2'd0);
    tick();
    checkOutput("fl_pre_occ", occupancy, 2'd2);
    applyStimulus(1'b1, 5'd9, 32'hF9, 32'h0, '0, 4'b0010, 2'd0);
    flush = 1'b1;
    tick();
    checkOutput("fl_full_occ", occupancy, 2'd0);
    checkOutput("fl_full_valid", bus.out_valid, 1'b0);
    checkOutput("fl_full_regwrite", bus.regwrite_out, 1'b0);

    // flush in ONE with a push that must be discarded
    flush = 1'b0;
    applyStimulus(1'b1, 5'd10, 32'h10, 32'h0, '0, 4'b0010, 2'd0);
    tick();
    checkOutput("fl_one_pre_occ", occupancy, 2'd1);
    applyStimulus(1'b1, 5'd11, 32'h11, 32'h0, '0, 4'b0010, 2'd0);
    flush = 1'b1;
    tick();
    checkOutput("fl_one_occ", occupancy, 2'd0);
    checkOutput("fl_one_valid", bus.out_valid, 1'b0);
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, '0, 4'b0000, 2'd0);
    tick();
    checkOutput("fl_after_occ", occupancy, 2'd0);
    checkOutput("fl_after_valid", bus.out_valid, 1'b0);

    // asynchronous reset while holding two entries
    applyStimulus(1'b1, 5'd21, 32'h5555, 32'hABCD, '1, 4'b1111, 2'd2);
    tick();
    applyStimulus(1'b1, 5'd22, 32'h6666, 32'h1111, '1, 4'b1111, 2'd1);
    tick();
    checkOutput("ar_pre_occ", occupancy, 2'd2);
    checkOutput("ar_pre_rd", bus.rd_out, 5'd21);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_occ", occupancy, 2'd0);
    checkOutput("ar_valid", bus.out_valid, 1'b0);
    checkOutput("ar_ready", bus.in_ready, 1'b1);
    checkOutput("ar_rd", bus.rd_out, 5'd0);
    checkOutput("ar_alu", bus.alu_result_out, 32'h0);
    checkOutput("ar_rdata", bus.readdata_out, 32'h0);
    checkOutput("ar_vdata", bus.readdata512_out, 512'd0);
    checkOutput("ar_vl", bus.VL_out, 2'd0);
    checkOutput("ar_regwrite", bus.regwrite_out, 1'b0);
    checkOutput("ar_svr", bus.SVRwrite_out, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, '0, 4'b0000, 2'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("ar_post_occ", occupancy, 2'd0);
    checkOutput("ar_post_valid", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
